mmio_timer_pwm_bank: RTL
========================

// Module: mmio_timer_pwm_bank
// PURPOSE
//  Parametrised multi-channel timer/PWM peripheral on the CPU MMIO bus; next generation of the single timer/PWM pair.
//  Each channel has a down-counter (auto-reload or one-shot), per-channel interrupt enable and a glitch-free PWM output.
//  A shared prescaler, a write-1-to-clear status register and one combined IRQ line to the CPU are added.
//  The bus address decoder drives sel; the block decodes addr[11:0] internally.
// PARAMETERS
//  N_CH     4   number of channels (1..8)
//  CNT_W    16  counter/LOAD width (1..32)
//  PWM_W    8   PWM counter/duty width (1..16)
//  PRESC_W  8   prescaler width; tick every PRESC+1 clk
// PORTS
//  clk      in   1       system clock, single clock domain
//  rst      in   1       synchronous, active-high reset
//  sel      in   1       bus select for this block
//  we       in   1       write strobe (qualified by sel)
//  be       in   4       byte enables for wdata
//  addr     in   12      byte offset in block
//  wdata    in   32      write data
//  rdata    out  32      read data, combinational, 0 when !sel or unmapped
//  irq      out  1       |(STATUS & IE), registered
//  pwm_out  out  N_CH    per-channel PWM outputs, registered
// BEHAVIOUR
//  Map: 0x000 STATUS[N_CH-1:0] (RO, W1C); 0x004 PRESC[PRESC_W-1:0] (RW).
//  Channel n at 0x100+n*0x10: +0 CTRL {OS[2],IE[1],EN[0]}; +4 LOAD; +8 COUNT (RO); +C DUTY.
//  Writes honour be per byte; bits above the field width are ignored and read back 0.
//  Reset: all regs 0, prescaler counter 0, irq=0, pwm_out=0, rdata follows decode.
//  Prescaler: pc counts 0..PRESC; tick=1 for one clk when pc==PRESC, then pc<=0; PRESC=0 -> tick every clk.
//  Write CTRL with EN 0->1: COUNT<=LOAD next clk (no tick needed). EN 1->0: COUNT holds.
//  On tick with EN=1: COUNT!=0 -> COUNT-1; COUNT==0 -> STATUS[n]<=1 and:
//    OS=0: COUNT<=LOAD (period LOAD+1 ticks); OS=1: EN<=0, COUNT stays 0.
//  LOAD write while running takes effect at the next reload only.
//  STATUS W1C: bit n cleared by writing 1 with be[0]; set event in same clk wins (bit stays 1).
//  irq registered: irq(t+1)=|(STATUS(t)&IE(t)); IE=0 masks irq but STATUS still sets.
//  PWM: per-channel pc_pwm (PWM_W) increments each tick when EN=1, wraps to 0.
//    pwm_out<=(pc_pwm<duty_act); DUTY write goes to shadow, copied to duty_act when pc_pwm wraps to 0
//    or when EN=0. DUTY=0 -> constant 0; DUTY=2^PWM_W-1 -> low 1 of 2^PWM_W ticks.
//  EN=0: pc_pwm held at 0, pwm_out<=0.
//  Writes with sel=0 or we=0 have no effect; unmapped writes ignored; channel n>=N_CH unmapped.
//  rst mid-operation: everything returns to reset values next clk; no pending event survives.
// STRUCTURE
//  Package mmio_pkg: offsets (STATUS_OFS, PRESC_OFS, CH_BASE, CH_STRIDE, CTRL/LOAD/COUNT/DUTY_OFS),
//   CTRL bit indices.
//  Sub-module mmio_timer_ch (one instance per channel via generate):
//   CTRL/LOAD/COUNT/DUTY + shadow, PWM counter; outputs event pulse, count, ctrl, pwm.
//  Top: prescaler, address decode, byte-enable merge, STATUS/irq, read mux.
// TESTING
//  PRESC=0, ch0 LOAD=3 EN=1 OS=0 -> STATUS[0] sets every 4 clk; IE=1 -> irq one clk after set.
//  PRESC=3, ch1 LOAD=2 OS=1 EN=1 -> STATUS[1] set after 12 clk, CTRL.EN reads 0, COUNT=0.
//  STATUS=0b0011, write 0x1 -> reads 0b0010; W1C same clk as ch0 event -> bit0 stays 1.
//  PWM_W=8, DUTY=64, EN=1 -> pwm_out high 64 of 256 ticks; DUTY->192 mid-period changes only after wrap.
//  LOAD write 5->9 while running -> current period ends at old count, next period 10 ticks.
//  rst asserted mid-count with irq=1 -> next clk irq=0, pwm_out=0, all registers read 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO timer/PWM bank: register offsets, channel
// layout, CTRL bit positions and a byte-enable to bit-mask helper.
package mmio_pkg;

    // Block-level registers
    localparam logic [11:0] STATUS_OFS = 12'h000;
    localparam logic [11:0] PRESC_OFS  = 12'h004;

    // Channel n lives at CH_BASE + n * CH_STRIDE
    localparam logic [11:0] CH_BASE    = 12'h100;
    localparam logic [11:0] CH_STRIDE  = 12'h010;

    // Offsets inside one channel window
    localparam logic [3:0] CTRL_OFS  = 4'h0;
    localparam logic [3:0] LOAD_OFS  = 4'h4;
    localparam logic [3:0] COUNT_OFS = 4'h8;
    localparam logic [3:0] DUTY_OFS  = 4'hC;

    // CTRL bit indices
    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_IE = 1;
    localparam int unsigned CTRL_OS = 2;

    // Expand 4 byte enables into a 32-bit write mask
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/mmio_timer_ch.sv
// One timer/PWM channel.
//  clk_i, rst_i          clock, synchronous active-high reset
//  tick_i                shared prescaler tick
//  ctrl_we_i/ctrl_wdata_i   CTRL write strobe and byte-merged value
//  load_we_i/load_wdata_i   LOAD write strobe and byte-merged value
//  duty_we_i/duty_wdata_i   DUTY (shadow) write strobe and byte-merged value
//  ctrl_o, load_o, count_o, duty_o   register readback
//  evt_o                 one-clk pulse when the counter expires on a tick
//  pwm_o                 registered PWM output
module mmio_timer_ch
    import mmio_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             ctrl_we_i,
    input  logic [2:0]       ctrl_wdata_i,
    input  logic             load_we_i,
    input  logic [CNT_W-1:0] load_wdata_i,
    input  logic             duty_we_i,
    input  logic [PWM_W-1:0] duty_wdata_i,
    output logic [2:0]       ctrl_o,
    output logic [CNT_W-1:0] load_o,
    output logic [CNT_W-1:0] count_o,
    output logic [PWM_W-1:0] duty_o,
    output logic             evt_o,
    output logic             pwm_o
);

    logic [2:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [PWM_W-1:0] duty_act_q, duty_act_d;
    logic [PWM_W-1:0] pc_pwm_q, pc_pwm_d;
    logic             pwm_q, pwm_d;
    logic             en;
    logic             evt;
    logic             wrap;

    assign en = ctrl_q[CTRL_EN];

    always_comb begin
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        count_d    = count_q;
        duty_d     = duty_q;
        duty_act_d = duty_act_q;
        pc_pwm_d   = pc_pwm_q;
        evt        = 1'b0;
        wrap       = 1'b0;

        if (load_we_i) load_d = load_wdata_i;
        if (duty_we_i) duty_d = duty_wdata_i;

        if (en && tick_i) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                evt = 1'b1;
                // Reload uses the LOAD register as it stands now, so a LOAD
                // write during a period only affects the following period.
                if (ctrl_q[CTRL_OS]) ctrl_d[CTRL_EN] = 1'b0;
                else                 count_d = load_q;
            end
            pc_pwm_d = pc_pwm_q + 1'b1;
            wrap     = (pc_pwm_q == '1);
        end

        if (!en) pc_pwm_d = '0;

        // A bus write to CTRL overrides a simultaneous one-shot disable
        if (ctrl_we_i) begin
            ctrl_d = ctrl_wdata_i;
            if (!en && ctrl_wdata_i[CTRL_EN]) count_d = load_q;
        end

        // Shadow duty is only adopted at a period boundary or while stopped
        if (!en || wrap) duty_act_d = duty_d;

        pwm_d = en && (pc_pwm_q < duty_act_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q     <= '0;
            load_q     <= '0;
            count_q    <= '0;
            duty_q     <= '0;
            duty_act_q <= '0;
            pc_pwm_q   <= '0;
            pwm_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            count_q    <= count_d;
            duty_q     <= duty_d;
            duty_act_q <= duty_act_d;
            pc_pwm_q   <= pc_pwm_d;
            pwm_q      <= pwm_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign load_o  = load_q;
    assign count_o = count_q;
    assign duty_o  = duty_q;
    assign evt_o   = evt;
    assign pwm_o   = pwm_q;

endmodule

// File: rtl/mmio_timer_pwm_bank.sv
// Multi-channel timer/PWM peripheral on the CPU MMIO bus.
//  clk, rst      clock, synchronous active-high reset
//  sel, we, be   bus select, write strobe, byte enables
//  addr          byte offset inside the block
//  wdata, rdata  write data, combinational read data (0 when !sel/unmapped)
//  irq           registered |(STATUS & IE)
//  pwm_out       per-channel registered PWM outputs
// Contains the shared prescaler, address decode, byte-enable merge,
// W1C STATUS register, irq and read mux.
module mmio_timer_pwm_bank
    import mmio_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PWM_W   = 8,
    parameter int unsigned PRESC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sel,
    input  logic            we,
    input  logic [3:0]      be,
    input  logic [11:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq,
    output logic [N_CH-1:0] pwm_out
);

    logic               wr;
    logic [31:0]        wmask;
    logic               ch_hit;
    logic               unused_bus;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pc_q, pc_d;
    logic               tick;
    logic [N_CH-1:0]    status_q, status_d;
    logic [N_CH-1:0]    status_clr;
    logic               irq_q, irq_d;

    logic [2:0]         ch_ctrl  [N_CH];
    logic [CNT_W-1:0]   ch_load  [N_CH];
    logic [CNT_W-1:0]   ch_count [N_CH];
    logic [PWM_W-1:0]   ch_duty  [N_CH];
    logic [N_CH-1:0]    ch_evt;
    logic [N_CH-1:0]    ie_vec;

    assign wr         = sel & we;
    assign wmask      = be_to_mask(be);
    assign ch_hit     = (addr[11:8] == CH_BASE[11:8]);
    assign unused_bus = ^{wdata, wmask};

    // Prescaler; >= keeps it from running away when PRESC is lowered below pc
    assign tick = (pc_q >= presc_q);

    always_comb begin
        pc_d    = tick ? '0 : pc_q + 1'b1;
        presc_d = presc_q;
        if (wr && addr == PRESC_OFS) begin
            presc_d = (presc_q & ~wmask[PRESC_W-1:0]) | (wdata[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
        end
    end

    // W1C clear loses to a same-cycle set
    assign status_clr = (wr && addr == STATUS_OFS && be[0]) ? wdata[N_CH-1:0] : '0;

    always_comb begin
        status_d = (status_q & ~status_clr) | ch_evt;
        irq_d    = |(status_q & ie_vec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            pc_q     <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            pc_q     <= pc_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             ch_sel;
        logic             ctrl_we;
        logic             load_we;
        logic             duty_we;
        logic [2:0]       ctrl_m;
        logic [CNT_W-1:0] load_m;
        logic [PWM_W-1:0] duty_m;

        assign ch_sel  = ch_hit && (addr[7:4] == 4'(i));
        assign ctrl_we = wr && ch_sel && (addr[3:0] == CTRL_OFS);
        assign load_we = wr && ch_sel && (addr[3:0] == LOAD_OFS);
        assign duty_we = wr && ch_sel && (addr[3:0] == DUTY_OFS);

        assign ctrl_m = (ch_ctrl[i] & ~wmask[2:0]) | (wdata[2:0] & wmask[2:0]);
        assign load_m = (ch_load[i] & ~wmask[CNT_W-1:0]) | (wdata[CNT_W-1:0] & wmask[CNT_W-1:0]);
        assign duty_m = (ch_duty[i] & ~wmask[PWM_W-1:0]) | (wdata[PWM_W-1:0] & wmask[PWM_W-1:0]);

        assign ie_vec[i] = ch_ctrl[i][CTRL_IE];

        mmio_timer_ch #(
            .CNT_W (CNT_W),
            .PWM_W (PWM_W)
        ) u_ch (
            .clk_i        (clk),
            .rst_i        (rst),
            .tick_i       (tick),
            .ctrl_we_i    (ctrl_we),
            .ctrl_wdata_i (ctrl_m),
            .load_we_i    (load_we),
            .load_wdata_i (load_m),
            .duty_we_i    (duty_we),
            .duty_wdata_i (duty_m),
            .ctrl_o       (ch_ctrl[i]),
            .load_o       (ch_load[i]),
            .count_o      (ch_count[i]),
            .duty_o       (ch_duty[i]),
            .evt_o        (ch_evt[i]),
            .pwm_o        (pwm_out[i])
        );
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            if (addr == STATUS_OFS) rdata = 32'(status_q);
            if (addr == PRESC_OFS)  rdata = 32'(presc_q);
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (ch_hit && addr[7:4] == 4'(i)) begin
                    case (addr[3:0])
                        CTRL_OFS:  rdata = 32'(ch_ctrl[i]);
                        LOAD_OFS:  rdata = 32'(ch_load[i]);
                        COUNT_OFS: rdata = 32'(ch_count[i]);
                        DUTY_OFS:  rdata = 32'(ch_duty[i]);
                        default:   rdata = '0;
                    endcase
                end
            end
        end
    end

endmodule
